mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
- Sequential instruction encoder and program loader: the encode direction of the MIPS control decoder.
- Accepts symbolic instruction requests (operation select plus register and immediate fields) over a valid/ready handshake.
- Assembles the 32-bit MIPS word for each request and writes it into instruction memory at consecutive word addresses from a programmed base.
- Used by the testbench or a boot sequencer to fill instruction memory before the core leaves reset.

Parameters:
AW, 8, instruction memory word-address width
CNT_W, 9, width of the words-written counter (holds 0..2^AW)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load session (ignored unless IDLE)
base_addr  input  AW  first word address, latched on start
in_valid  input  1  instruction request valid
in_ready  output  1  encoder can accept a request this cycle
in_last  input  1  marks the final request of the session
op_sel  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9-15 illegal
rs  input  5  source register field
rt  input  5  second source / I-type destination field
rd  input  5  R-type destination field
imm  input  16  immediate / offset field
imem_we  output  1  memory write request
imem_addr  output  AW  memory word address
imem_wdata  output  32  encoded instruction
mem_busy  input  1  memory stall; a write completes only on a cycle with imem_we=1 and mem_busy=0
busy  output  1  high in LOAD and DRAIN
done  output  1  one-cycle pulse when the session completes
word_count  output  CNT_W  words written in the current or last session
err_illegal  output  1  sticky; an illegal op_sel was accepted
err_wrap  output  1  sticky; the address wrapped from 2^AW-1 to 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready, imem_we, busy, done, err_illegal, err_wrap = 0.
  - imem_addr, imem_wdata, word_count = 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - On start=1: latch base_addr into the address register, clear word_count, err_illegal and err_wrap, go to LOAD.
- LOAD:
  - in_ready = !(imem_we && mem_busy).
  - A request is accepted when in_valid && in_ready.
  - Accepted word appears on imem_wdata with imem_we=1 the next cycle (1-cycle latency).
  - Encoding, R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}; funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - Encoding, I-type: {opcode, rs, rt, imm}; opcode ADDI 001000, LW 100011, SW 101011, BEQ 000100.
  - rd is ignored for I-type.
  - Illegal op_sel: word 32'h00000000 (nop) is written and err_illegal is set.
- Write completion (imem_we && !mem_busy):
  - word_count increments.
  - imem_addr increments modulo 2^AW; the step from 2^AW-1 to 0 sets err_wrap.
  - If no new request is accepted in the same cycle, imem_we drops to 0.
- Back-to-back:
  - An acceptance in the same cycle as a completion loads the next word, keeping imem_we=1 with the incremented address.
  - Sustained throughput is 1 word/cycle when mem_busy=0.
- Stall: while mem_busy=1, imem_we, imem_addr and imem_wdata hold stable and in_ready=0.
- Session end:
  - Acceptance with in_last=1 moves to DRAIN; in_ready=0 in DRAIN.
  - DRAIN -> DONE when the last write completes.
  - DONE asserts done for exactly one cycle, then returns to IDLE.
  - word_count and the error flags hold until the next start.
- Ignored inputs: start is ignored outside IDLE; in_valid is ignored outside LOAD.
- Reset mid-session: immediate return to reset values. A pending write is dropped; no partial write follows.

Test Plan:
- start base_addr=0x10; ADD rs=1 rt=2 rd=3 (last) -> next cycle imem_we=1, addr 0x10, wdata 0x00221820; done pulses 2 cycles later; word_count=1.
- Back-to-back LW rs=0 rt=8 imm=0x0004, BEQ rs=1 rt=2 imm=0xFFFF, SW rs=29 rt=31 imm=0x0008 (last), mem_busy=0 -> consecutive writes 0x8C080004, 0x1022FFFF, 0xAFBF0008 at base, base+1, base+2; word_count=3.
- SLT rs=4 rt=5 rd=6 with mem_busy=1 for 3 cycles -> wdata 0x0085302A and addr held stable, in_ready=0 during the stall; exactly one write completes; count increments once.
- op_sel=12 accepted -> wdata 0x00000000 written; err_illegal=1 stays set through done until the next start.
- base_addr=2^AW-1, two requests -> writes at 2^AW-1 then 0; err_wrap=1.
- rst_n low while imem_we=1 and mem_busy=1 -> imem_we=0 immediately; state IDLE; a subsequent start works normally.

Source files
------------

// File: rtl/mips_instr_encoder_if.sv
// Request and instruction-memory bus of the MIPS instruction encoder.
// The slave modport is the encoder; the master side issues requests and owns memory.
interface mips_instr_encoder_if #(
   parameter int AW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [3:0]    op_sel;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [4:0]    rd;
   logic [15:0]   imm;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          mem_busy;

   modport slave (
      input  in_valid, in_last, op_sel, rs, rt, rd, imm, mem_busy,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output in_valid, in_last, op_sel, rs, rt, rd, imm, mem_busy,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/mips_instr_encoder.sv
// Sequential MIPS instruction encoder: turns symbolic requests into 32-bit words
// and writes them to instruction memory at consecutive addresses from a base.
module mips_instr_encoder #(
   parameter int AW    = 8,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [AW-1:0]    base_addr,
   mips_instr_encoder_if.slave bus,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] word_count,
   output logic             err_illegal,
   output logic             err_wrap
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t      state;
   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        accept;
   logic        complete;

   always_comb begin
      enc_word    = 32'h0000_0000;
      enc_illegal = 1'b0;
      case (bus.op_sel)
         4'd0: enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100000};
         4'd1: enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100010};
         4'd2: enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100100};
         4'd3: enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100101};
         4'd4: enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b101010};
         4'd5: enc_word = {6'b001000, bus.rs, bus.rt, bus.imm};
         4'd6: enc_word = {6'b100011, bus.rs, bus.rt, bus.imm};
         4'd7: enc_word = {6'b101011, bus.rs, bus.rt, bus.imm};
         4'd8: enc_word = {6'b000100, bus.rs, bus.rt, bus.imm};
         default: enc_illegal = 1'b1;
      endcase
   end

   // Ready must fall in the same cycle memory stalls, so it is decoded from mem_busy directly.
   assign bus.in_ready = (state == LOAD) && !(bus.imem_we && bus.mem_busy);
   assign accept       = bus.in_valid && bus.in_ready;
   assign complete     = bus.imem_we && !bus.mem_busy;
   assign busy         = (state == LOAD) || (state == DRAIN);
   assign done         = (state == DONE);

   // imem_addr always holds the address of the pending or next write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= 32'h0000_0000;
         word_count     <= '0;
         err_illegal    <= 1'b0;
         err_wrap       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bus.imem_addr <= base_addr;
                  word_count    <= '0;
                  err_illegal   <= 1'b0;
                  err_wrap      <= 1'b0;
                  state         <= LOAD;
               end
            end
            LOAD, DRAIN: begin
               if (complete) begin
                  word_count    <= word_count + CNT_W'(1);
                  bus.imem_addr <= bus.imem_addr + AW'(1);
                  bus.imem_we   <= 1'b0;
                  if (bus.imem_addr == {AW{1'b1}})
                     err_wrap <= 1'b1;
                  if (state == DRAIN)
                     state <= DONE;
               end
               if (accept) begin
                  bus.imem_we    <= 1'b1;
                  bus.imem_wdata <= enc_word;
                  if (enc_illegal)
                     err_illegal <= 1'b1;
                  if (bus.in_last)
                     state <= DRAIN;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed self-checking bench for mips_instr_encoder with hand-computed encodings.
module tb_mips_instr_encoder;

   localparam int AW    = 8;
   localparam int CNT_W = 9;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [AW-1:0]    base_addr;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] word_count;
   logic             err_illegal;
   logic             err_wrap;

   int checks;
   int errors;

   mips_instr_encoder_if #(.AW(AW)) bus ();

   mips_instr_encoder #(.AW(AW), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .bus         (bus.slave),
      .busy        (busy),
      .done        (done),
      .word_count  (word_count),
      .err_illegal (err_illegal),
      .err_wrap    (err_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic [3:0] op, input logic [4:0] s,
                          input logic [4:0] t, input logic [4:0] d,
                          input logic [15:0] im, input logic last);
      bus.in_valid = v;
      bus.op_sel   = op;
      bus.rs       = s;
      bus.rt       = t;
      bus.rd       = d;
      bus.imm      = im;
      bus.in_last  = last;
   endtask

   task automatic begin_session(input logic [AW-1:0] base);
      start     = 1'b1;
      base_addr = base;
      step();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.in_ready, bus.imem_we, busy, done, err_illegal, err_wrap} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b want 000000",
                  {bus.in_ready, bus.imem_we, busy, done, err_illegal, err_wrap});
      end
      checks++;
      if (bus.imem_addr !== 8'h00 || bus.imem_wdata !== 32'h0 || word_count !== 9'd0) begin
         errors++;
         $display("[TB] FAIL reset_values got addr=%h wdata=%h cnt=%0d want 0/0/0",
                  bus.imem_addr, bus.imem_wdata, word_count);
      end
   endtask

   task automatic test_single();
      begin_session(8'h10);
      set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
      checks++;
      if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_ready got ready=%b busy=%b want 1 1", bus.in_ready, busy);
      end
      step();
      set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'h10 || bus.imem_wdata !== 32'h00221820) begin
         errors++;
         $display("[TB] FAIL single_write got we=%b addr=%h wdata=%h want 1 10 00221820",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drain_ready got %b want 0", bus.in_ready);
      end
      step();
      checks++;
      if (done !== 1'b1 || word_count !== 9'd1 || bus.imem_we !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_done got done=%b cnt=%0d we=%b busy=%b want 1 1 0 0",
                  done, word_count, bus.imem_we, busy);
      end
      step();
      checks++;
      if (done !== 1'b0 || word_count !== 9'd1) begin
         errors++;
         $display("[TB] FAIL single_after got done=%b cnt=%0d want 0 1", done, word_count);
      end
   endtask

   task automatic test_back_to_back();
      begin_session(8'h20);
      set_req(1'b1, 4'd6, 5'd0, 5'd8, 5'd0, 16'h0004, 1'b0);
      step();
      set_req(1'b1, 4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b0);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'h20 || bus.imem_wdata !== 32'h8C080004) begin
         errors++;
         $display("[TB] FAIL b2b_lw got we=%b addr=%h wdata=%h want 1 20 8C080004",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end
      step();
      set_req(1'b1, 4'd7, 5'd29, 5'd31, 5'd0, 16'h0008, 1'b1);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'h21 || bus.imem_wdata !== 32'h1022FFFF) begin
         errors++;
         $display("[TB] FAIL b2b_beq got we=%b addr=%h wdata=%h want 1 21 1022FFFF",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end
      step();
      set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'h22 || bus.imem_wdata !== 32'hAFBF0008) begin
         errors++;
         $display("[TB] FAIL b2b_sw got we=%b addr=%h wdata=%h want 1 22 AFBF0008",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end
      step();
      checks++;
      if (done !== 1'b1 || word_count !== 9'd3) begin
         errors++;
         $display("[TB] FAIL b2b_done got done=%b cnt=%0d want 1 3", done, word_count);
      end
      step();
   endtask

   task automatic test_stall();
      begin_session(8'h30);
      set_req(1'b1, 4'd4, 5'd4, 5'd5, 5'd6, 16'h0, 1'b0);
      step();
      set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
      bus.mem_busy = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'h30 || bus.imem_wdata !== 32'h0085302A ||
             bus.in_ready !== 1'b0 || word_count !== 9'd0) begin
            errors++;
            $display("[TB] FAIL stall_hold%0d got we=%b addr=%h wdata=%h ready=%b cnt=%0d want 1 30 0085302A 0 0",
                     i, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.in_ready, word_count);
         end
         step();
      end
      bus.mem_busy = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_release_ready got %b want 1", bus.in_ready);
      end
      step();
      set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
      checks++;
      if (word_count !== 9'd1 || bus.imem_addr !== 8'h31 || bus.imem_wdata !== 32'h00221820) begin
         errors++;
         $display("[TB] FAIL stall_after got cnt=%0d addr=%h wdata=%h want 1 31 00221820",
                  word_count, bus.imem_addr, bus.imem_wdata);
      end
      step();
      checks++;
      if (done !== 1'b1 || word_count !== 9'd2) begin
         errors++;
         $display("[TB] FAIL stall_done got done=%b cnt=%0d want 1 2", done, word_count);
      end
      step();
   endtask

   task automatic test_illegal();
      begin_session(8'h40);
      set_req(1'b1, 4'd12, 5'd7, 5'd7, 5'd7, 16'h1234, 1'b1);
      step();
      set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_wdata !== 32'h0 || err_illegal !== 1'b1) begin
         errors++;
         $display("[TB] FAIL illegal_write got we=%b wdata=%h err=%b want 1 00000000 1",
                  bus.imem_we, bus.imem_wdata, err_illegal);
      end
      step();
      step();
      checks++;
      if (err_illegal !== 1'b1 || done !== 1'b0 || word_count !== 9'd1) begin
         errors++;
         $display("[TB] FAIL illegal_sticky got err=%b done=%b cnt=%0d want 1 0 1",
                  err_illegal, done, word_count);
      end
   endtask

   task automatic test_wrap();
      begin_session(8'hFF);
      checks++;
      if (err_illegal !== 1'b0 || word_count !== 9'd0) begin
         errors++;
         $display("[TB] FAIL start_clear got err=%b cnt=%0d want 0 0", err_illegal, word_count);
      end
      set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
      step();
      set_req(1'b1, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
      checks++;
      if (bus.imem_addr !== 8'hFF || err_wrap !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_first got addr=%h wrap=%b want FF 0", bus.imem_addr, err_wrap);
      end
      step();
      set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
      checks++;
      if (bus.imem_addr !== 8'h00 || bus.imem_wdata !== 32'h00221822 || err_wrap !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wrap_second got addr=%h wdata=%h wrap=%b want 00 00221822 1",
                  bus.imem_addr, bus.imem_wdata, err_wrap);
      end
      step();
      step();
      checks++;
      if (err_wrap !== 1'b1 || word_count !== 9'd2) begin
         errors++;
         $display("[TB] FAIL wrap_sticky got wrap=%b cnt=%0d want 1 2", err_wrap, word_count);
      end
   endtask

   task automatic test_reset_mid();
      begin_session(8'h50);
      set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
      step();
      set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
      bus.mem_busy = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.imem_we !== 1'b0 || busy !== 1'b0 || bus.imem_addr !== 8'h00 ||
          bus.imem_wdata !== 32'h0 || word_count !== 9'd0) begin
         errors++;
         $display("[TB] FAIL midreset got we=%b busy=%b addr=%h wdata=%h cnt=%0d want 0 0 00 0 0",
                  bus.imem_we, busy, bus.imem_addr, bus.imem_wdata, word_count);
      end
      bus.mem_busy = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (bus.imem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_nowrite got we=%b want 0", bus.imem_we);
      end
      begin_session(8'h60);
      set_req(1'b1, 4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
      step();
      set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'h60 || bus.imem_wdata !== 32'h00221825) begin
         errors++;
         $display("[TB] FAIL restart_write got we=%b addr=%h wdata=%h want 1 60 00221825",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end
      step();
      checks++;
      if (done !== 1'b1 || word_count !== 9'd1) begin
         errors++;
         $display("[TB] FAIL restart_done got done=%b cnt=%0d want 1 1", done, word_count);
      end
      step();
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      base_addr    = '0;
      bus.mem_busy = 1'b0;
      set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
      step();
      step();
      test_reset();
      rst_n = 1'b1;
      step();
      test_single();
      test_back_to_back();
      test_stall();
      test_illegal();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
